bus_mux_reg: RTL and testbench
==============================

# bus_mux_reg

Registered, parametrised datapath bus multiplexer with one-hot source drive enables. It is the next generation of the CPU datapath's combinational 32-to-1 bus selector. It adds:

- a built-in priority encoder
- a one-cycle registered bus output
- an idle hold mode
- detection and counting of multiple-driver conflicts

It sits between the register file and special registers (HI, LO, Z, PC, MDR, in-port, C sign-extended) and every bus consumer.

## Interface

Parameters:

- WIDTH, 32, bus data width in bits
- SOURCES, 24, number of bus sources (2..32)
- SEL_W, 5, width of encoded source index; must satisfy 2^SEL_W > SOURCES
- HOLD_IDLE, 1, 1 = bus keeps last value when no source drives; 0 = bus goes to zero
- CNT_W, 8, width of saturating conflict counter

Ports:

- clock, input, 1, rising-edge clock
- clear, input, 1, asynchronous active-low reset
- src_data, input, SOURCES*WIDTH, flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- src_out, input, SOURCES, one-hot drive enables (R0out, R1out, ... order = index)
- conflict_clr, input, 1, synchronous clear of conflict_flag and conflict_cnt
- bus_q, output, WIDTH, registered bus value
- bus_valid, output, 1, high when bus_q was loaded from a source in the previous cycle
- bus_sel, output, SEL_W, index of the source captured into bus_q; SOURCES = none
- conflict, output, 1, registered pulse: more than one src_out bit was high in the previous cycle
- conflict_flag, output, 1, sticky conflict indicator
- conflict_cnt, output, CNT_W, saturating count of conflict cycles

## Operation

Combinational front end:

- Priority encoder over src_out; the lowest set index wins.
- Popcount is only needed to the extent of detecting 0, 1 or more than 1 bits set.

Per rising edge, when clear is high:

- **Exactly one bit i set:** bus_q <= src_data[i]; bus_sel <= i; bus_valid <= 1; conflict <= 0.
- **More than one bit set:** lowest index i is captured as above; conflict <= 1; conflict_flag <= 1; conflict_cnt <= conflict_cnt+1, saturating at all-ones.
- **No bit set:** bus_valid <= 0; bus_sel <= SOURCES; conflict <= 0.
  - HOLD_IDLE=1: bus_q unchanged.
  - HOLD_IDLE=0: bus_q <= 0.
- **conflict_clr high:** conflict_flag <= 0 and conflict_cnt <= 0. This takes priority over an increment in the same cycle. conflict (the pulse) is still set if that cycle has a conflict.
- **Parameter misconfiguration:** SOURCES > 2^SEL_W - 1 is a configuration error. A simulation-time check is required to flag it.

State: there is no FSM. Registered state is bus_q, bus_sel, bus_valid, conflict, conflict_flag and conflict_cnt.

## Timing

- **Reset values:** clear low immediately forces:
  - bus_q = 0
  - bus_valid = 0
  - bus_sel = SOURCES
  - conflict = 0
  - conflict_flag = 0
  - conflict_cnt = 0
- **Reset release:** after release, the first capture happens on the first rising edge with clear high.
- **Reset mid-operation:** outputs go to reset values asynchronously; no pending capture survives.
- **Latency:** src_out/src_data sampled at edge N appear on bus_q at edge N (visible the following cycle). There is exactly one cycle of latency, and the throughput is one transfer per cycle.
- **Consumer timing:** consumers that load from the bus (MAR, Y, registers) must assert their in-enable one cycle after the corresponding out-enable.
- **Input stability:** src_data need only be stable around the sampling edge; there is no combinational path from any input to any output.
- **Counter saturation:** conflict_cnt holds at 2^CNT_W-1; conflict_flag stays 1.
- **Clear during saturation:** conflict_clr while saturated returns the count to 0.

## Test plan

1. **Reset:** clear low mid-transfer with src_out=1<<3 → all outputs at reset values immediately. bus_sel=24 with defaults.
2. **Single-source sweep:** for each i in 0..23, src_out=1<<i with src_data[i]=32'hA000_0000+i → next cycle bus_q=32'hA000_0000+i, bus_sel=i, bus_valid=1, conflict=0.
3. **Idle hold:** drive source 5 (32'h1234_5678), then src_out=0 → HOLD_IDLE=1 keeps bus_q=32'h1234_5678 with bus_valid=0 and bus_sel=24. Rebuilt with HOLD_IDLE=0 → bus_q=0.
4. **Conflict:** src_out=(1<<2)|(1<<7) → bus_q=src_data[2], bus_sel=2, conflict=1, conflict_flag=1, conflict_cnt=1. The next clean cycle gives conflict=0 with the flag remaining 1.
5. **Saturation and clear:** 300 consecutive conflict cycles → conflict_cnt=255. Then conflict_clr with a simultaneous conflict → conflict_cnt=0, conflict_flag=0, conflict=1.
6. **Back-to-back:** alternate sources 16 (HI=32'hFFFF_FFFF) and 17 (LO=32'h0) every cycle → bus_q toggles every cycle, one cycle behind src_out, with no bubbles.

Source files
------------

// File: rtl/bus_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_mux_reg
//  Purpose  : Registered datapath bus multiplexer. Selects the lowest-index
//             source whose drive enable is set, registers the bus value,
//             and detects and counts multiple-driver conflicts.
//  Revision : 1.0  initial release
// ============================================================================
module bus_mux_reg #(
  parameter int WIDTH     = 32,
  parameter int SOURCES   = 24,
  parameter int SEL_W     = 5,
  parameter bit HOLD_IDLE = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [SOURCES*WIDTH-1:0]   src_data,
  input  logic [SOURCES-1:0]         src_out,
  input  logic                       conflict_clr,
  output logic [WIDTH-1:0]           bus_q,
  output logic                       bus_valid,
  output logic [SEL_W-1:0]           bus_sel,
  output logic                       conflict,
  output logic                       conflict_flag,
  output logic [CNT_W-1:0]           conflict_cnt
);

  // Encoded index meaning "no source captured".
  localparam logic [SEL_W-1:0]   c_SEL_NONE = SEL_W'(SOURCES);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SOURCES-1:0] c_ONE      = {{(SOURCES-1){1'b0}}, 1'b1};

  // The encoding must leave SOURCES itself free as the "none" code.
  generate
    if ((SOURCES < 2) || (SOURCES > (2**SEL_W) - 1)) begin : g_cfg_error
      $error("bus_mux_reg: SOURCES=%0d does not fit SEL_W=%0d (need 2 <= SOURCES <= 2**SEL_W-1)",
             SOURCES, SEL_W);
    end else begin : g_cfg_ok
    end
  endgenerate

  logic [SEL_W-1:0] w_win_idx;
  logic [WIDTH-1:0] w_win_data;
  logic             w_any;
  logic             w_multi;

  logic [WIDTH-1:0] bus_d;
  logic             bus_valid_d, bus_valid_q;
  logic [SEL_W-1:0] bus_sel_d, bus_sel_q;
  logic             conflict_d, conflict_q;
  logic             conflict_flag_d, conflict_flag_q;
  logic [CNT_W-1:0] conflict_cnt_d, conflict_cnt_q;

  // Priority encoder: scan from the top so the lowest set index wins last.
  always_comb begin
    w_win_idx  = c_SEL_NONE;
    w_win_data = '0;
    w_any      = 1'b0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        w_win_idx  = SEL_W'(i);
        w_win_data = src_data[i*WIDTH +: WIDTH];
        w_any      = 1'b1;
      end
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi = |(src_out & (src_out - c_ONE));

  // Next-state computation for all bus and conflict registers.
  always_comb begin
    bus_d           = bus_q;
    bus_valid_d     = 1'b0;
    bus_sel_d       = c_SEL_NONE;
    conflict_d      = 1'b0;
    conflict_flag_d = conflict_flag_q;
    conflict_cnt_d  = conflict_cnt_q;

    if (w_any) begin
      bus_d       = w_win_data;
      bus_valid_d = 1'b1;
      bus_sel_d   = w_win_idx;
    end else if (!HOLD_IDLE) begin
      bus_d = '0;
    end

    if (w_multi) begin
      conflict_d      = 1'b1;
      conflict_flag_d = 1'b1;
      if (conflict_cnt_q != c_CNT_MAX) begin
        conflict_cnt_d = conflict_cnt_q + 1'b1;
      end
    end

    // Software clear wins over a same-cycle increment; the pulse is unaffected.
    if (conflict_clr) begin
      conflict_flag_d = 1'b0;
      conflict_cnt_d  = '0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_q           <= '0;
      bus_valid_q     <= 1'b0;
      bus_sel_q       <= c_SEL_NONE;
      conflict_q      <= 1'b0;
      conflict_flag_q <= 1'b0;
      conflict_cnt_q  <= '0;
    end else begin
      bus_q           <= bus_d;
      bus_valid_q     <= bus_valid_d;
      bus_sel_q       <= bus_sel_d;
      conflict_q      <= conflict_d;
      conflict_flag_q <= conflict_flag_d;
      conflict_cnt_q  <= conflict_cnt_d;
    end
  end

  assign bus_valid     = bus_valid_q;
  assign bus_sel       = bus_sel_q;
  assign conflict      = conflict_q;
  assign conflict_flag = conflict_flag_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_mux_reg
//  Purpose  : Directed self-checking bench for bus_mux_reg (hold and
//             zero-on-idle builds driven from the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_mux_reg;

  localparam int WIDTH   = 32;
  localparam int SOURCES = 24;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  logic                     clock;
  logic                     clear;
  logic [SOURCES*WIDTH-1:0] src_data;
  logic [SOURCES-1:0]       src_out;
  logic                     conflict_clr;

  logic [WIDTH-1:0] bus_q,  bus_q0;
  logic             bus_valid, bus_valid0;
  logic [SEL_W-1:0] bus_sel, bus_sel0;
  logic             conflict, conflict0;
  logic             conflict_flag, conflict_flag0;
  logic [CNT_W-1:0] conflict_cnt, conflict_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  bus_mux_reg #(.WIDTH(WIDTH), .SOURCES(SOURCES), .SEL_W(SEL_W),
                .HOLD_IDLE(1'b1), .CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
    .conflict_clr(conflict_clr), .bus_q(bus_q), .bus_valid(bus_valid),
    .bus_sel(bus_sel), .conflict(conflict), .conflict_flag(conflict_flag),
    .conflict_cnt(conflict_cnt));

  bus_mux_reg #(.WIDTH(WIDTH), .SOURCES(SOURCES), .SEL_W(SEL_W),
                .HOLD_IDLE(1'b0), .CNT_W(CNT_W)) dut_zero (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
    .conflict_clr(conflict_clr), .bus_q(bus_q0), .bus_valid(bus_valid0),
    .bus_sel(bus_sel0), .conflict(conflict0), .conflict_flag(conflict_flag0),
    .conflict_cnt(conflict_cnt0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_src(input int idx, input logic [WIDTH-1:0] val);
    src_data[idx*WIDTH +: WIDTH] = val;
  endtask

  initial begin
    clear        = 1'b0;
    conflict_clr = 1'b0;
    src_out      = '0;
    src_data     = '0;
    for (int i = 0; i < SOURCES; i++) set_src(i, 32'hA000_0000 + i);

    // Reset values, then an asynchronous clear during a live transfer.
    cyc(); cyc();
    check_eq("rst_bus_q",   bus_q,         0);
    check_eq("rst_sel",     bus_sel,       24);
    clear   = 1'b1;
    src_out = 24'(1) << 3;
    cyc();
    check_eq("pre_rst_valid", bus_valid,   1);
    check_eq("pre_rst_bus",   bus_q,       32'hA000_0003);
    #2 clear = 1'b0;
    #1;
    check_eq("async_bus_q",   bus_q,         0);
    check_eq("async_valid",   bus_valid,     0);
    check_eq("async_sel",     bus_sel,       24);
    check_eq("async_conf",    conflict,      0);
    check_eq("async_flag",    conflict_flag, 0);
    check_eq("async_cnt",     conflict_cnt,  0);
    @(negedge clock);
    src_out = '0;
    clear   = 1'b1;

    // Single-source sweep.
    for (int i = 0; i < SOURCES; i++) begin
      src_out = 24'(1) << i;
      cyc();
      check_eq($sformatf("sweep_bus_%0d", i),   bus_q,     32'hA000_0000 + i);
      check_eq($sformatf("sweep_sel_%0d", i),   bus_sel,   i);
      check_eq($sformatf("sweep_valid_%0d", i), bus_valid, 1);
      check_eq($sformatf("sweep_conf_%0d", i),  conflict,  0);
    end

    // Idle behaviour: hold build keeps the value, zero build clears.
    set_src(5, 32'h1234_5678);
    src_out = 24'(1) << 5;
    cyc();
    check_eq("idle_load_bus",  bus_q,  32'h1234_5678);
    check_eq("idle_load_bus0", bus_q0, 32'h1234_5678);
    src_out = '0;
    cyc();
    check_eq("idle_hold_bus",   bus_q,      32'h1234_5678);
    check_eq("idle_hold_valid", bus_valid,  0);
    check_eq("idle_hold_sel",   bus_sel,    24);
    check_eq("idle_zero_bus",   bus_q0,     0);
    check_eq("idle_zero_valid", bus_valid0, 0);
    check_eq("idle_zero_sel",   bus_sel0,   24);
    cyc();
    check_eq("idle_hold_bus2",  bus_q,      32'h1234_5678);

    // Two drivers: lowest index wins, conflict recorded.
    src_out = (24'(1) << 2) | (24'(1) << 7);
    cyc();
    check_eq("conf_bus",   bus_q,         32'hA000_0002);
    check_eq("conf_sel",   bus_sel,       2);
    check_eq("conf_pulse", conflict,      1);
    check_eq("conf_flag",  conflict_flag, 1);
    check_eq("conf_cnt",   conflict_cnt,  1);
    src_out = 24'(1) << 9;
    cyc();
    check_eq("clean_pulse", conflict,      0);
    check_eq("clean_flag",  conflict_flag, 1);
    check_eq("clean_cnt",   conflict_cnt,  1);
    check_eq("clean_bus",   bus_q,         32'hA000_0009);

    // Saturation, then clear with a simultaneous conflict.
    src_out = (24'(1) << 1) | (24'(1) << 23);
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (k == 253) check_eq("cnt_254", conflict_cnt, 255);
    end
    check_eq("sat_cnt",  conflict_cnt,  255);
    check_eq("sat_flag", conflict_flag, 1);
    check_eq("sat_bus",  bus_q,         32'hA000_0001);
    conflict_clr = 1'b1;
    cyc();
    conflict_clr = 1'b0;
    check_eq("clr_cnt",   conflict_cnt,  0);
    check_eq("clr_flag",  conflict_flag, 0);
    check_eq("clr_pulse", conflict,      1);
    cyc();
    check_eq("post_clr_cnt",  conflict_cnt,  1);
    check_eq("post_clr_flag", conflict_flag, 1);

    // Back-to-back alternation between HI and LO, no bubbles.
    set_src(16, 32'hFFFF_FFFF);
    set_src(17, 32'h0000_0000);
    for (int k = 0; k < 8; k++) begin
      src_out = (k % 2 == 0) ? (24'(1) << 16) : (24'(1) << 17);
      cyc();
      check_eq($sformatf("b2b_bus_%0d", k),   bus_q,     (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      check_eq($sformatf("b2b_sel_%0d", k),   bus_sel,   (k % 2 == 0) ? 16 : 17);
      check_eq($sformatf("b2b_valid_%0d", k), bus_valid, 1);
    end
    src_out = '0;
    cyc();
    check_eq("b2b_end_valid", bus_valid, 0);
    check_eq("b2b_end_bus0",  bus_q0,    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
